// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared sizes and types for the single-clock show-ahead byte FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;

  typedef logic [DSIZE-1:0] data_t;
  // One bit wider than the address; the MSB tells full apart from empty
  typedef logic [ASIZE:0]   ptr_t;
  typedef logic [ASIZE-1:0] addr_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_modport_mem.sv
`default_nettype none
// ============================================================================
// Module : fifo_modport_mem
// Brief  : DEPTH x DSIZE register array with a synchronous write port and an
//          asynchronous read port. The array is cleared on reset so the read
//          port never returns unknown data.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_modport_mem
  import fifo_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_we,
  input  addr_t i_waddr,
  input  data_t i_wdata,
  input  addr_t i_raddr,
  output data_t o_rdata
);

  data_t r_mem [DEPTH];

  // Storage: clear every word on reset, otherwise write the addressed word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Show-ahead read: the addressed word is visible without a clock edge
  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_modport_mem
`default_nettype wire

// File: rtl/fifo_modport.sv
`default_nettype none
// ============================================================================
// Module : fifo_modport
// Brief  : Single-clock 16 x 8 show-ahead FIFO with the winc/wfull and
//          rinc/rempty handshake. Holds the pointers, the registered flags
//          and the request gating; storage lives in fifo_modport_mem.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_modport
  import fifo_pkg::*;
(
  input  logic           wclk,
  input  logic           wrst,
  input  logic           winc,
  input  data_t          wdata,
  output logic           wfull,
  input  logic           rinc,
  output data_t          rdata,
  output logic           rempty,
  output logic [ASIZE:0] count
);

  ptr_t  r_wptr;
  ptr_t  r_rptr;
  logic  r_wfull;
  logic  r_rempty;

  logic  w_we;
  logic  w_re;
  ptr_t  w_wptr_next;
  ptr_t  w_rptr_next;
  logic  w_full_next;
  logic  w_empty_next;

  // Each side is gated only by its own current flag, so a simultaneous
  // write at full or read at empty is silently dropped on that side alone
  assign w_we = winc && !r_wfull;
  assign w_re = rinc && !r_rempty;

  assign w_wptr_next = r_wptr + {{ASIZE{1'b0}}, w_we};
  assign w_rptr_next = r_rptr + {{ASIZE{1'b0}}, w_re};

  // Flags come from the next-state pointers so they move on the same edge
  assign w_empty_next = (w_wptr_next == w_rptr_next);
  assign w_full_next  = (w_wptr_next[ASIZE] != w_rptr_next[ASIZE]) &&
                        (w_wptr_next[ASIZE-1:0] == w_rptr_next[ASIZE-1:0]);

  // Pointer and flag registers
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
    end else begin
      r_wptr   <= w_wptr_next;
      r_rptr   <= w_rptr_next;
      r_wfull  <= w_full_next;
      r_rempty <= w_empty_next;
    end
  end

  fifo_modport_mem u_mem (
    .i_clk   (wclk),
    .i_rst   (wrst),
    .i_we    (w_we),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (rdata)
  );

  // Occupancy is the modular pointer distance; the wrap bit makes 16 distinct from 0
  assign count  = r_wptr - r_rptr;
  assign wfull  = r_wfull;
  assign rempty = r_rempty;

endmodule : fifo_modport
`default_nettype wire

// File: tb/tb_fifo_modport.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_modport
// Brief  : Self-checking bench for fifo_modport: a table of hand-computed
//          vectors plus directed sequences for fill, wrap, simultaneous
//          access, underflow and asynchronous reset. A queue model tracks
//          the expected contents across every cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_modport;
  import fifo_pkg::*;

  logic           wclk;
  logic           wrst;
  logic           winc;
  data_t          wdata;
  logic           wfull;
  logic           rinc;
  data_t          rdata;
  logic           rempty;
  logic [ASIZE:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  data_t q[$];

  typedef struct {
    logic           wi;
    data_t          wd;
    logic           ri;
    logic [ASIZE:0] ecount;
    logic           eempty;
    logic           efull;
    data_t          erdata;
  } vec_t;

  vec_t vecs[10];

  fifo_modport dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty),
    .count  (count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Continuous invariants, sampled away from the active edge
  always @(negedge wclk) begin
    if (wrst === 1'b0) begin
      chk("flags_exclusive", {31'd0, (wfull && rempty)}, 32'd0);
      if (rempty === 1'b0) chk("rdata_known", {31'd0, $isunknown(rdata)}, 32'd0);
    end
  end

  // One clock of stimulus; the model applies the same gating then all outputs are compared
  task automatic step(input logic wi, input data_t wd, input logic ri);
    bit m_full;
    bit m_empty;
    winc  = wi;
    wdata = wd;
    rinc  = ri;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    @(posedge wclk);
    if (ri && !m_empty) void'(q.pop_front());
    if (wi && !m_full)  q.push_back(wd);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    chk("model_count",  32'(count),  32'(q.size()));
    chk("model_rempty", 32'(rempty), 32'(q.size() == 0));
    chk("model_wfull",  32'(wfull),  32'(q.size() == DEPTH));
    if (q.size() != 0) chk("model_rdata", 32'(rdata), 32'(q[0]));
  endtask

  // Mid-cycle asynchronous reset with an immediate check, no edge required
  task automatic async_reset(input string tag);
    @(posedge wclk);
    #2;
    wrst = 1'b1;
    #1;
    q.delete();
    chk({tag, "_rempty"}, 32'(rempty), 32'd1);
    chk({tag, "_wfull"},  32'(wfull),  32'd0);
    chk({tag, "_count"},  32'(count),  32'd0);
    chk({tag, "_rdata"},  32'(rdata),  32'h00);
    #1;
    wrst = 1'b0;
  endtask

  initial begin
    wrst  = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 8'h11};
    vecs[3] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 8'h11};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 5'd2, 1'b0, 1'b0, 8'h22};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h33};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b1, 8'h44, 1'b1, 5'd1, 1'b0, 1'b0, 8'h44};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};

    repeat (2) @(posedge wclk);
    #2;
    wrst = 1'b0;

    // Reset asserted mid-cycle with data inside
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h6B, 1'b0);
    async_reset("reset");

    // Table of single-word, mixed and underflow vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wi, vecs[i].wd, vecs[i].ri);
      chk($sformatf("vec%0d_count", i),  32'(count),  32'(vecs[i].ecount));
      chk($sformatf("vec%0d_rempty", i), 32'(rempty), 32'(vecs[i].eempty));
      chk($sformatf("vec%0d_wfull", i),  32'(wfull),  32'(vecs[i].efull));
      if (!vecs[i].eempty) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].erdata));
    end

    // Fill to full, attempt an overflow, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, data_t'(i), 1'b0);
    chk("fill_wfull", 32'(wfull), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 8'hFF, 1'b0);
    chk("overflow_count", 32'(count), 32'd16);
    chk("overflow_head",  32'(rdata), 32'h00);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d_rdata", i), 32'(rdata), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("drain_rempty", 32'(rempty), 32'd1);

    // Interleaved traffic carries both pointers past 2*DEPTH
    for (int i = 0; i < 40; i++) begin
      step(1'b1, data_t'(i), 1'b0);
      chk($sformatf("wrap%0d_rdata", i), 32'(rdata), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("wrap_rempty", 32'(rempty), 32'd1);

    // Simultaneous read and write at count 5
    for (int i = 0; i < 5; i++) step(1'b1, data_t'(8'h50 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, data_t'(8'h60 + i), 1'b1);
      chk($sformatf("simul%0d_count", i), 32'(count), 32'd5);
    end
    chk("simul_head", 32'(rdata), 32'h53);
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1);

    // Simultaneous at full: only the pop happens
    for (int i = 0; i < DEPTH; i++) step(1'b1, data_t'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("fullsim_count", 32'(count), 32'd15);
    chk("fullsim_wfull", 32'(wfull), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("fullsim_drain%0d", i), 32'(rdata), 32'(8'h80 + i));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("fullsim_empty", 32'(rempty), 32'd1);

    // Underflow leaves the state untouched
    step(1'b0, 8'h00, 1'b1);
    chk("under_count",  32'(count),  32'd0);
    chk("under_rempty", 32'(rempty), 32'd1);

    // Reset with 7 entries, then only new data comes out
    for (int i = 0; i < 7; i++) step(1'b1, data_t'(8'hC0 + i), 1'b0);
    chk("midfill_count", 32'(count), 32'd7);
    async_reset("midfill_reset");
    step(1'b1, 8'h77, 1'b0);
    chk("post_reset_rdata", 32'(rdata), 32'h77);
    chk("post_reset_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_reset_empty", 32'(rempty), 32'd1);

    repeat (2) @(posedge wclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_modport
`default_nettype wire
